// File: rtl/link_frame_scheduler_if.sv
// UART FIFO-side signals of the link frame scheduler: TX FIFO write port and
// first-word-fall-through RX FIFO read port.
interface link_frame_scheduler_if;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (
    input  tx_full, rx_empty, r_data,
    output wr_uart, w_data, rd_uart
  );

  modport slave (
    output tx_full, rx_empty, r_data,
    input  wr_uart, w_data, rd_uart
  );
endinterface

// File: rtl/link_frame_scheduler.sv
// Two-player UART link: sends a sync/payload/checksum frame per frame tick and
// parses, verifies and latches the peer's frames, tracking link health.
module link_frame_scheduler #(
  parameter int unsigned PAYLOAD_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic [8*PAYLOAD_BYTES-1:0]   tx_payload,
  link_frame_scheduler_if.master       uart,
  output logic [8*PAYLOAD_BYTES-1:0]   rx_payload,
  output logic                         rx_valid,
  output logic                         crc_err,
  output logic                         link_ok,
  output logic                         tx_busy
);
  localparam int unsigned      IDX_W   = $clog2(PAYLOAD_BYTES + 2);
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IDX_W-1:0] TX_LAST = IDX_W'(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS);

  // ---------------- TX path ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t                  tx_state, tx_state_next;
  logic [IDX_W-1:0]           tx_idx;
  logic [8*PAYLOAD_BYTES-1:0] tx_shadow;
  logic [7:0]                 tx_sum;
  logic                       tx_start;
  logic                       tx_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_idx    <= '0;
      tx_shadow <= '0;
    end else begin
      tx_state <= tx_state_next;
      if (tx_start) begin
        tx_shadow <= tx_payload;
        tx_idx    <= '0;
      end else if (tx_wr) begin
        tx_idx <= tx_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_start      = 1'b0;
    tx_wr         = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (frame_tick) begin
          tx_start      = 1'b1;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_wr = ~uart.tx_full;
        if (tx_wr && (tx_idx == TX_LAST)) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // Index 0 is the sync byte, 1..N the shadowed payload, N+1 the checksum.
  always_comb begin
    tx_sum = '0;
    for (int unsigned k = 0; k < PAYLOAD_BYTES; k++)
      tx_sum = tx_sum + tx_shadow[8*k +: 8];
    uart.w_data = SYNC_BYTE;
    for (int unsigned k = 0; k < PAYLOAD_BYTES; k++)
      if (tx_idx == IDX_W'(k + 1)) uart.w_data = tx_shadow[8*k +: 8];
    if (tx_idx == TX_LAST) uart.w_data = tx_sum;
  end

  assign uart.wr_uart = tx_wr;
  assign tx_busy      = (tx_state == TX_SEND);

  // ---------------- RX path ----------------
  typedef enum logic [1:0] {RX_HUNT, RX_PAYLOAD, RX_CHECK} rx_state_t;

  rx_state_t                  rx_state, rx_state_next;
  logic [IDX_W-1:0]           rx_idx;
  logic [7:0]                 rx_sum;
  logic [8*PAYLOAD_BYTES-1:0] rx_shadow;
  logic                       pop;
  logic                       good_frame;
  logic                       bad_frame;
  logic [CNT_W-1:0]           tick_cnt;

  assign pop          = ~uart.rx_empty & ~rst;
  assign uart.rd_uart = pop;

  always_comb begin
    rx_state_next = rx_state;
    good_frame    = 1'b0;
    bad_frame     = 1'b0;
    if (pop) begin
      case (rx_state)
        RX_HUNT:    if (uart.r_data == SYNC_BYTE) rx_state_next = RX_PAYLOAD;
        RX_PAYLOAD: if (rx_idx == RX_LAST) rx_state_next = RX_CHECK;
        RX_CHECK: begin
          rx_state_next = RX_HUNT;
          good_frame    = (uart.r_data == rx_sum);
          bad_frame     = (uart.r_data != rx_sum);
        end
        default: rx_state_next = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_HUNT;
      rx_idx     <= '0;
      rx_sum     <= '0;
      rx_shadow  <= '0;
      rx_payload <= '0;
      rx_valid   <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      rx_valid <= good_frame;
      crc_err  <= bad_frame;
      if (pop && (rx_state == RX_HUNT) && (uart.r_data == SYNC_BYTE)) begin
        rx_idx <= '0;
        rx_sum <= '0;
      end
      if (pop && (rx_state == RX_PAYLOAD)) begin
        rx_idx <= rx_idx + IDX_W'(1);
        rx_sum <= rx_sum + uart.r_data;
        for (int unsigned k = 0; k < PAYLOAD_BYTES; k++)
          if (rx_idx == IDX_W'(k)) rx_shadow[8*k +: 8] <= uart.r_data;
      end
      if (good_frame) rx_payload <= rx_shadow;
    end
  end

  // A good frame overrides a coincident frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      link_ok  <= 1'b0;
    end else if (good_frame) begin
      tick_cnt <= '0;
      link_ok  <= 1'b1;
    end else if (frame_tick) begin
      if (tick_cnt >= CNT_MAX - CNT_W'(1)) begin
        tick_cnt <= CNT_MAX;
        link_ok  <= 1'b0;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_link_frame_scheduler.sv
// Directed bench for link_frame_scheduler: TX framing with stalls, RX accept/
// reject, link timeout and mid-frame reset.
module tb_link_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [15:0] tx_payload;
  logic [15:0] rx_payload;
  logic        rx_valid, crc_err, link_ok, tx_busy;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  link_frame_scheduler_if uart_if ();

  link_frame_scheduler #(
    .PAYLOAD_BYTES(2),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_TICKS(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .tx_payload(tx_payload),
    .uart      (uart_if.master),
    .rx_payload(rx_payload),
    .rx_valid  (rx_valid),
    .crc_err   (crc_err),
    .link_ok   (link_ok),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One TX frame; tx_full held high for stall_len cycles once stall_at bytes are out.
  task automatic run_tx(input string tag, input logic [15:0] pay, input logic [7:0] exp[4],
                        input int unsigned stall_at, input int unsigned stall_len);
    logic [7:0]  got[$];
    int unsigned cyc_cnt = 0;
    int unsigned stalled = 0;
    @(posedge clk); #1 frame_tick = 1'b1; tx_payload = pay;
    @(negedge clk);
    check({tag, "_wr_at_tick"}, 32'(uart_if.wr_uart), 32'd0);
    @(posedge clk); #1 frame_tick = 1'b0;
    while (cyc_cnt < 20) begin
      uart_if.tx_full = (got.size() == stall_at) && (stalled < stall_len);
      @(negedge clk);
      if (!tx_busy) break;
      if (uart_if.tx_full) begin
        stalled++;
        check({tag, "_wr_while_full"}, 32'(uart_if.wr_uart), 32'd0);
      end
      if (uart_if.wr_uart) got.push_back(uart_if.w_data);
      cyc_cnt++;
      @(posedge clk); #1;
    end
    uart_if.tx_full = 1'b0;
    check({tag, "_nbytes"}, 32'(got.size()), 32'd4);
    check({tag, "_busy_cycles"}, cyc_cnt, 4 + stall_len);
    for (int unsigned i = 0; i < 4; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    check({tag, "_wr_after"}, 32'(uart_if.wr_uart), 32'd0);
  endtask

  // Feeds n bytes back to back; returns at the negedge of the cycle after the last pop.
  task automatic rx_bytes(input logic [7:0] b[5], input int unsigned n, input logic tick_last);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1 uart_if.rx_empty = 1'b0; uart_if.r_data = b[i];
      frame_tick = tick_last && (i == n - 1);
      @(negedge clk);
      check("rd_uart_pop", 32'(uart_if.rd_uart), 32'd1);
    end
    @(posedge clk); #1 uart_if.rx_empty = 1'b1; frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (4) @(posedge clk);
    end
    #1;
    @(negedge clk);
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; tx_payload = '0;
    uart_if.tx_full = 1'b0; uart_if.rx_empty = 1'b1; uart_if.r_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_wr_uart", 32'(uart_if.wr_uart), 32'd0);
    check("rst_rd_uart", 32'(uart_if.rd_uart), 32'd0);
    check("rst_link_ok", 32'(link_ok), 32'd0);
    check("rst_rx_payload", 32'(rx_payload), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_crc_err", 32'(crc_err), 32'd0);

    run_tx("tx_plain", 16'h3412, '{8'hA5, 8'h12, 8'h34, 8'h46}, 99, 0);
    run_tx("tx_stall", 16'h3412, '{8'hA5, 8'h12, 8'h34, 8'h46}, 2, 3);
    run_tx("tx_wrap",  16'hF0C3, '{8'hA5, 8'hC3, 8'hF0, 8'hB3}, 0, 2);

    rx_bytes('{8'h00, 8'hA5, 8'h07, 8'h09, 8'h10}, 5, 1'b0);
    check("rx_good_payload", 32'(rx_payload), 32'h0907);
    check("rx_good_valid", 32'(rx_valid), 32'd1);
    check("rx_good_crc_err", 32'(crc_err), 32'd0);
    check("rx_good_link", 32'(link_ok), 32'd1);
    next_cycle();
    check("rx_valid_pulse", 32'(rx_valid), 32'd0);

    rx_bytes('{8'hA5, 8'h07, 8'h09, 8'h11, 8'h00}, 4, 1'b0);
    check("rx_bad_crc_err", 32'(crc_err), 32'd1);
    check("rx_bad_valid", 32'(rx_valid), 32'd0);
    check("rx_bad_payload", 32'(rx_payload), 32'h0907);
    check("rx_bad_link", 32'(link_ok), 32'd1);
    next_cycle();
    check("crc_err_pulse", 32'(crc_err), 32'd0);

    rx_bytes('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00}, 4, 1'b0);
    check("rx_after_bad_payload", 32'(rx_payload), 32'h0201);
    check("rx_after_bad_valid", 32'(rx_valid), 32'd1);

    tick_n(15);
    check("timeout_15_link", 32'(link_ok), 32'd1);
    tick_n(1);
    check("timeout_16_link", 32'(link_ok), 32'd0);

    rx_bytes('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00}, 4, 1'b0);
    check("relink", 32'(link_ok), 32'd1);
    tick_n(15);
    rx_bytes('{8'hA5, 8'h05, 8'h06, 8'h0B, 8'h00}, 4, 1'b1);
    check("tick_vs_good_link", 32'(link_ok), 32'd1);
    check("tick_vs_good_payload", 32'(rx_payload), 32'h0605);
    tick_n(15);
    check("cnt_cleared_link", 32'(link_ok), 32'd1);
    tick_n(1);
    check("cnt_cleared_drop", 32'(link_ok), 32'd0);

    rx_bytes('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00}, 4, 1'b0);
    @(posedge clk); #1 frame_tick = 1'b1; tx_payload = 16'h3412;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    check("mid_rst_b0", 32'(uart_if.w_data), 32'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_b1", 32'(uart_if.w_data), 32'h12);
    @(posedge clk); #1 rst = 1'b1; uart_if.rx_empty = 1'b0; uart_if.r_data = 8'hA5;
    @(negedge clk);
    check("rst_blocks_pop", 32'(uart_if.rd_uart), 32'd0);
    @(posedge clk); #1 rst = 1'b0; uart_if.rx_empty = 1'b1;
    @(negedge clk);
    check("mid_rst_wr", 32'(uart_if.wr_uart), 32'd0);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_link", 32'(link_ok), 32'd0);
    check("mid_rst_payload", 32'(rx_payload), 32'd0);
    run_tx("tx_after_rst", 16'h3412, '{8'hA5, 8'h12, 8'h34, 8'h46}, 99, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/link_frame_scheduler.md
# link_frame_scheduler

Sequences the two-player UART link for the racing game. On each frame tick it sends one framed packet of local player state: a sync byte, the payload bytes, and a checksum. In parallel it parses the peer's incoming packets, verifies their checksum, latches accepted payloads, and tracks link health with a frame-tick timeout. It sits between the game-state logic and the UART TX/RX FIFOs, replacing ad-hoc single-byte exchange with a checked multi-byte protocol.

## Interface
Parameters:
- PAYLOAD_BYTES, 2: payload bytes per frame (1..8).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_TICKS, 16: frame ticks without a good frame before the link is declared down (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse that starts a TX frame and advances the timeout counter.
- tx_payload  in  8*PAYLOAD_BYTES  local state. Byte k is bits [8k+7:8k]; byte 0 is sent first.
- tx_full  in  1  TX FIFO full.
- wr_uart  out  1  TX FIFO write strobe.
- w_data  out  8  TX FIFO write data.
- rx_empty  in  1  RX FIFO empty. The FIFO is first-word-fall-through, so r_data is valid whenever rx_empty=0.
- r_data  in  8  RX FIFO head byte.
- rd_uart  out  1  RX FIFO pop strobe.
- rx_payload  out  8*PAYLOAD_BYTES  last accepted peer payload, same byte order as tx_payload.
- rx_valid  out  1  one-cycle pulse when rx_payload updates.
- crc_err  out  1  one-cycle pulse when a frame is rejected.
- link_ok  out  1  peer link alive.
- tx_busy  out  1  TX frame in progress.

## Operation
Checksum: sum of the payload bytes mod 256, 8-bit wrap. The sync byte is not included.

TX FSM (TX_IDLE, TX_SEND):
- In TX_IDLE, frame_tick snapshots tx_payload into a shadow register, clears the byte index, and moves to TX_SEND.
- w_data is selected by index:
  - 0: SYNC_BYTE
  - 1..PAYLOAD_BYTES: shadow byte index-1
  - PAYLOAD_BYTES+1: checksum of the shadow.
- wr_uart = (state==TX_SEND) & ~tx_full, decoded combinationally.
- Each cycle wr_uart=1, the index increments. After the checksum byte is written, the FSM returns to TX_IDLE.
- tx_full stalls the index with no byte lost or duplicated.
- frame_tick while in TX_SEND is ignored; no queueing.
- tx_busy = (state==TX_SEND).

RX FSM (RX_HUNT, RX_PAYLOAD, RX_CHECK):
- rd_uart = ~rx_empty & ~rst; every available byte is popped in the same cycle it is examined.
- RX_HUNT: a popped byte equal to SYNC_BYTE clears the index and running sum, then moves to RX_PAYLOAD. Any other byte is discarded.
- RX_PAYLOAD: the popped byte is stored at the index and added to the running sum. After PAYLOAD_BYTES bytes, move to RX_CHECK. A SYNC_BYTE value here is treated as ordinary data; there is no resynchronisation.
- RX_CHECK: the popped byte is compared with the running sum, then the FSM returns to RX_HUNT.
  - Match: rx_payload <= shadow, rx_valid pulses, the timeout counter clears, link_ok <= 1.
  - Mismatch: crc_err pulses; rx_payload and link_ok are unchanged.

Timeout:
- The counter, width clog2(TIMEOUT_TICKS+1), increments on frame_tick and saturates at TIMEOUT_TICKS.
- Reaching TIMEOUT_TICKS sets link_ok <= 0.
- If a good frame and a frame_tick land in the same cycle, the good frame wins: the counter becomes 0 and link_ok is 1.

Reset values: rx_payload 0, rx_valid 0, crc_err 0, link_ok 0, tx_busy 0, wr_uart 0, rd_uart 0. TX FSM goes to TX_IDLE, RX FSM to RX_HUNT, counter to 0. A reset mid-frame abandons the partial TX frame; the UART peer recovers through hunting.

## Timing
- TX: w_data and wr_uart are combinational from registered state; wr_uart is combinational with tx_full.
  - A frame_tick at cycle T gives the first wr_uart (sync byte) at T+1.
  - With tx_full=0 throughout, the frame occupies T+1..T+PAYLOAD_BYTES+2 contiguously.
  - tx_busy falls at T+PAYLOAD_BYTES+3.
- RX: one byte is consumed per cycle whenever rx_empty=0.
  - If the checksum byte is popped at cycle N, rx_payload, rx_valid, crc_err and link_ok update at the clock edge ending N and are visible at N+1.
  - rx_valid and crc_err are high for exactly one cycle.
- The TX and RX paths run independently; simultaneous activity has no interaction.

## Test plan
- PAYLOAD_BYTES=2, tx_payload=16'h3412, frame_tick, tx_full=0 → wr_uart for 4 consecutive cycles with w_data A5,12,34,46; then tx_busy=0.
- Same frame with tx_full forced high for 3 cycles after the second byte → sequence still A5,12,34,46 with no gaps beyond the stall and no duplicates.
- RX bytes 00,A5,07,09,10 → 00 discarded; rx_payload=16'h0907, rx_valid one pulse, link_ok=1.
- RX bytes A5,07,09,11 → crc_err pulse; rx_payload and link_ok unchanged. A following A5,01,02,03 is accepted.
- After link_ok=1, issue 16 frame_ticks with no RX → link_ok drops on the 16th. A good frame in the same cycle as the 16th tick → link_ok stays 1.
- rst asserted mid-TX, after 2 bytes → wr_uart 0 next cycle, tx_busy 0, outputs at reset values; the next frame_tick starts a fresh frame beginning with A5.
